// File: rtl/line_anim_engine.sv
`default_nettype none
// ============================================================================
// Module      : line_anim_engine
// Description : Pixel-write engine for the translating-line demo. A Bresenham
//               line is drawn, erased and redrawn one column to the right on
//               every update tick; a synchronised clear request sweeps the
//               framebuffer black in raster order.
// Revision    : 1.0 - initial release
// ============================================================================
module line_anim_engine #(
    parameter int DIV_BIT = 21,
    parameter int X0      = 0,
    parameter int Y0      = 0,
    parameter int X1      = 100,
    parameter int Y1      = 50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_async,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        pixel_color,
    output logic        pixel_write
);

    localparam int c_DX_I   = X1 - X0;
    localparam int c_DY_I   = Y1 - Y0;
    localparam int c_ADX    = (c_DX_I < 0) ? -c_DX_I : c_DX_I;
    localparam int c_ADY    = (c_DY_I < 0) ? -c_DY_I : c_DY_I;
    localparam logic c_MAJ_X = (c_ADX >= c_ADY);
    localparam int c_N      = c_MAJ_X ? c_ADX : c_ADY;
    localparam int c_M      = c_MAJ_X ? c_ADY : c_ADX;
    localparam logic c_SX_NEG = (c_DX_I < 0);
    localparam logic c_SY_NEG = (c_DY_I < 0);
    localparam int c_XMAX_I = (X0 > X1) ? X0 : X1;

    localparam logic [10:0] c_X0        = 11'(X0);
    localparam logic [10:0] c_Y0        = 11'(Y0);
    localparam logic [10:0] c_N_CNT     = 11'(c_N);
    localparam logic [10:0] c_OFF_LIM   = 11'(639 - c_XMAX_I);
    localparam logic [10:0] c_PX_LAST   = 11'd639;
    localparam logic [10:0] c_PY_LAST   = 11'd479;
    localparam logic signed [13:0] c_ERR0     = 14'(2 * c_M - c_N);
    localparam logic signed [13:0] c_ERR_STR  = 14'(2 * c_M);
    localparam logic signed [13:0] c_ERR_DIAG = 14'(2 * c_M - 2 * c_N);

    localparam logic [1:0] c_ST_DRAW  = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_ERASE = 2'd2;
    localparam logic [1:0] c_ST_MOVE  = 2'd3;

    logic        r_sync1, r_sync2, r_div_bit_q;
    logic [31:0] r_div;
    logic        w_clr, w_tick, w_unused;

    logic [1:0]         r_state, w_state;
    logic [10:0]        r_px, w_px, r_py, w_py, r_off, w_off;
    logic [10:0]        r_cx, w_cx, r_cy, w_cy, r_cnt, w_cnt;
    logic signed [13:0] r_err, w_err;
    logic [10:0]        r_x, w_x, r_y, w_y;
    logic               r_color, w_color, r_write, w_write;
    logic [10:0]        w_line_off;
    logic               w_load, w_minor;

    assign w_clr    = r_sync2;
    assign w_tick   = r_div[DIV_BIT] & ~r_div_bit_q;
    assign w_unused = ^r_div;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_div       <= '0;
            r_div_bit_q <= 1'b0;
        end else begin
            r_sync1     <= clear_async;
            r_sync2     <= r_sync1;
            r_div_bit_q <= r_div[DIV_BIT];
            r_div       <= w_clr ? 32'd0 : r_div + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_DRAW;
            r_px    <= '0;
            r_py    <= '0;
            r_off   <= '0;
            r_cx    <= c_X0;
            r_cy    <= c_Y0;
            r_err   <= c_ERR0;
            r_cnt   <= c_N_CNT;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state;
            r_px    <= w_px;
            r_py    <= w_py;
            r_off   <= w_off;
            r_cx    <= w_cx;
            r_cy    <= w_cy;
            r_err   <= w_err;
            r_cnt   <= w_cnt;
            r_x     <= w_x;
            r_y     <= w_y;
            r_color <= w_color;
            r_write <= w_write;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_px       = r_px;
        w_py       = r_py;
        w_off      = r_off;
        w_cx       = r_cx;
        w_cy       = r_cy;
        w_err      = r_err;
        w_cnt      = r_cnt;
        w_x        = r_x;
        w_y        = r_y;
        w_color    = r_color;
        w_write    = 1'b0;
        w_line_off = r_off;
        w_load     = 1'b0;
        w_minor    = 1'b0;

        if (w_clr) begin
            w_x     = r_px;
            w_y     = r_py;
            w_color = 1'b0;
            w_write = 1'b1;
            if (r_px == c_PX_LAST) begin
                w_px = '0;
                w_py = (r_py == c_PY_LAST) ? 11'd0 : r_py + 11'd1;
            end else begin
                w_px = r_px + 11'd1;
            end
            w_state    = c_ST_DRAW;
            w_off      = '0;
            w_line_off = '0;
            w_load     = 1'b1;
        end else begin
            case (r_state)
                c_ST_DRAW, c_ST_ERASE: begin
                    w_x     = r_cx;
                    w_y     = r_cy;
                    w_color = (r_state == c_ST_DRAW);
                    w_write = 1'b1;
                    if (r_cnt == 11'd0) begin
                        w_state = (r_state == c_ST_DRAW) ? c_ST_IDLE : c_ST_MOVE;
                    end else begin
                        w_cnt = r_cnt - 11'd1;
                        // Strict '>' makes exact half-way points stay on the A side.
                        if (r_err > 14'sd0) begin
                            w_minor = 1'b1;
                            w_err   = r_err + c_ERR_DIAG;
                        end else begin
                            w_err   = r_err + c_ERR_STR;
                        end
                        if (c_MAJ_X || w_minor)
                            w_cx = c_SX_NEG ? r_cx - 11'd1 : r_cx + 11'd1;
                        if (!c_MAJ_X || w_minor)
                            w_cy = c_SY_NEG ? r_cy - 11'd1 : r_cy + 11'd1;
                    end
                end
                c_ST_IDLE: begin
                    if (w_tick) begin
                        w_state = c_ST_ERASE;
                        w_load  = 1'b1;
                    end
                end
                default: begin
                    w_off      = (r_off >= c_OFF_LIM) ? 11'd0 : r_off + 11'd1;
                    w_line_off = w_off;
                    w_load     = 1'b1;
                    w_state    = c_ST_DRAW;
                end
            endcase
        end

        if (w_load) begin
            w_cx  = c_X0 + w_line_off;
            w_cy  = c_Y0;
            w_err = c_ERR0;
            w_cnt = c_N_CNT;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign pixel_color = r_color;
    assign pixel_write = r_write;

endmodule
`default_nettype wire

// File: tb/tb_line_anim_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_anim_engine
// Description : Scoreboard bench for line_anim_engine: three line shapes, random
//               clear episodes, offset wrap and tick timing.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_line_anim_engine;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } pix_t;

    localparam int c_ALL = 100000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr0;
    logic [10:0] xo [3];
    logic [10:0] yo [3];
    logic        co [3];
    logic        wo [3];

    always #5 clk = ~clk;

    line_anim_engine #(.DIV_BIT(4), .X0(0), .Y0(0), .X1(4), .Y1(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .clear_async(clr0),
        .x(xo[0]), .y(yo[0]), .pixel_color(co[0]), .pixel_write(wo[0]));
    line_anim_engine #(.DIV_BIT(4), .X0(10), .Y0(0), .X1(10), .Y1(20)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clear_async(1'b0),
        .x(xo[1]), .y(yo[1]), .pixel_color(co[1]), .pixel_write(wo[1]));
    line_anim_engine #(.DIV_BIT(4), .X0(9), .Y0(5), .X1(0), .Y1(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .clear_async(1'b0),
        .x(xo[2]), .y(yo[2]), .pixel_color(co[2]), .pixel_write(wo[2]));

    int ax [3] = '{0, 10, 9};
    int ay [3] = '{0, 0, 5};
    int bx [3] = '{4, 10, 0};
    int by [3] = '{2, 20, 2};

    pix_t q [3][$];
    int   off_m [3] = '{0, 0, 0};
    int   px_m = 0, py_m = 0;
    int   n_pass = 0, n_total = 0;
    int   cyc = 0, first_cyc = -1;
    int   erase_cyc [$];
    int   seen [3] = '{0, 0, 0};
    logic last_c0 = 1'b0;
    bit   done = 1'b0, abort = 1'b0;
    pix_t got_p, exp_p;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sgn(input int v);
        return (v < 0) ? -1 : 1;
    endfunction

    // Ideal line: minor coordinate is i*m/n rounded to nearest, halves toward A.
    function automatic void push_line(input int k, input int off, input logic col, input int limit);
        int dx, dy, n, m, mn, xx, yy;
        bit xmaj;
        dx   = bx[k] - ax[k];
        dy   = by[k] - ay[k];
        xmaj = iabs(dx) >= iabs(dy);
        n    = xmaj ? iabs(dx) : iabs(dy);
        m    = xmaj ? iabs(dy) : iabs(dx);
        for (int i = 0; i <= n && i < limit; i++) begin
            mn = (n == 0) ? 0 : (2 * i * m + n - 1) / (2 * n);
            if (xmaj) begin
                xx = ax[k] + off + i * sgn(dx);
                yy = ay[k] + mn * sgn(dy);
            end else begin
                xx = ax[k] + off + mn * sgn(dx);
                yy = ay[k] + i * sgn(dy);
            end
            q[k].push_back({11'(xx), 11'(yy), col});
        end
    endfunction

    function automatic int next_off(input int k, input int off);
        int xm;
        xm = (ax[k] > bx[k]) ? ax[k] : bx[k];
        return (xm + off + 1 > 639) ? 0 : off + 1;
    endfunction

    function automatic void push_cycle(input int k);
        push_line(k, off_m[k], 1'b0, c_ALL);
        off_m[k] = next_off(k, off_m[k]);
        push_line(k, off_m[k], 1'b1, c_ALL);
    endfunction

    function automatic void push_clear(input int n);
        for (int i = 0; i < n; i++) begin
            q[0].push_back({11'(px_m), 11'(py_m), 1'b0});
            px_m++;
            if (px_m == 640) begin
                px_m = 0;
                py_m = (py_m == 479) ? 0 : py_m + 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic wait_drain(input int bound);
        int t;
        t = 0;
        while (q[0].size() != 0 && t < bound && !abort) begin
            @(negedge clk);
            t++;
        end
        if (q[0].size() != 0 && !abort) begin
            n_total++;
            $display("FAIL drain u0: %0d writes pending after %0d cycles, expected 0", q[0].size(), bound);
            abort = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset_n && !done) begin
            for (int k = 0; k < 3; k++) begin
                if (wo[k] === 1'b1) begin
                    got_p = {xo[k], yo[k], co[k]};
                    seen[k]++;
                    if (k == 0) begin
                        if (first_cyc < 0) first_cyc = cyc;
                        if (co[0] == 1'b0 && last_c0 == 1'b1) erase_cyc.push_back(cyc);
                        last_c0 = co[0];
                    end
                    n_total++;
                    if (q[k].size() == 0) begin
                        $display("FAIL pix u%0d: got write (%0d,%0d,c%0d) expected no write",
                                 k, got_p.x, got_p.y, got_p.c);
                    end else begin
                        exp_p = q[k].pop_front();
                        if (got_p == exp_p) n_pass++;
                        else $display("FAIL pix u%0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                                      k, got_p.x, got_p.y, got_p.c, exp_p.x, exp_p.y, exp_p.c);
                    end
                end
            end
            if (n_total - n_pass > 50) abort = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && !done) begin
            for (int k = 1; k < 3; k++)
                if (q[k].size() < 64) push_cycle(k);
        end
    end

    initial begin
        int n_clr, n_ab, n_re;
        clr0    = 1'b0;
        reset_n = 1'b0;
        push_line(0, 0, 1'b1, c_ALL);
        for (int k = 1; k < 3; k++) begin
            push_line(k, 0, 1'b1, c_ALL);
            push_cycle(k);
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset x u%0d", k), int'(xo[k]), 0);
            chk($sformatf("reset y u%0d", k), int'(yo[k]), 0);
            chk($sformatf("reset color u%0d", k), int'(co[k]), 0);
            chk($sformatf("reset write u%0d", k), int'(wo[k]), 0);
        end
        reset_n = 1'b1;

        for (int i = 0; i < 30 && !abort; i++) begin
            wait_drain(3000);
            if (abort) break;
            if (i == 2 || i == 3 || (i >= 4 && $urandom_range(0, 2) == 0)) begin
                n_clr = (i == 2) ? 700 : int'($urandom_range(1, 1000));
                n_ab  = int'($urandom_range(1, 4));
                n_re  = int'($urandom_range(1, 50));
                push_clear(n_clr);
                if (i == 3) begin
                    push_line(0, 0, 1'b1, n_ab);
                    push_clear(n_re);
                end
                off_m[0] = 0;
                push_line(0, 0, 1'b1, c_ALL);
                clr0 = 1'b1;
                repeat (n_clr) @(negedge clk);
                clr0 = 1'b0;
                if (i == 3) begin
                    repeat (n_ab) @(negedge clk);
                    clr0 = 1'b1;
                    repeat (n_re) @(negedge clk);
                    clr0 = 1'b0;
                end
            end else begin
                push_cycle(0);
            end
        end

        for (int i = 0; i < 640 && !abort; i++) begin
            wait_drain(3000);
            push_cycle(0);
        end
        wait_drain(3000);

        chk("first draw cycle", first_cyc, 1);
        chk("first erase cycle", (erase_cyc.size() > 0) ? erase_cyc[0] : -1, 18);
        chk("second erase cycle", (erase_cyc.size() > 1) ? erase_cyc[1] : -1, 50);
        chk("u1 activity", int'(seen[1] >= 2000), 1);
        chk("u2 activity", int'(seen[2] >= 2000), 1);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        if (!done) begin
            done = 1'b1;
            n_total++;
            $display("FAIL watchdog: got cycle budget exhausted expected completion");
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

endmodule
`default_nettype wire
